// File: rtl/instr_register_ctrl_if.sv
// Bundles the requester, instruction-register and consumer signals of the controller.
// No logic and no latency; only wires grouped for port connection.
// slave is the controller view, master is the environment (requesters, register, consumer).
interface instr_register_ctrl_if #(
    parameter int DEPTH = 32,
    parameter int PTR_W = 5,
    parameter int OPC_W = 4,
    parameter int OPD_W = 32,
    parameter int IW_W  = 132
);
    // requester side
    logic        [1:0]       req_valid;
    logic        [1:0]       req_ready;
    logic        [OPC_W-1:0] req0_opcode;
    logic signed [OPD_W-1:0] req0_op_a;
    logic signed [OPD_W-1:0] req0_op_b;
    logic        [OPC_W-1:0] req1_opcode;
    logic signed [OPD_W-1:0] req1_op_a;
    logic signed [OPD_W-1:0] req1_op_b;

    // instruction register side
    logic                    load_en;
    logic        [PTR_W-1:0] write_pointer;
    logic        [OPC_W-1:0] opcode;
    logic signed [OPD_W-1:0] operand_a;
    logic signed [OPD_W-1:0] operand_b;
    logic        [PTR_W-1:0] read_pointer;
    logic        [IW_W-1:0]  instruction_word;

    // consumer side
    logic                    rd_valid;
    logic                    rd_ready;
    logic        [IW_W-1:0]  rd_data;

    // occupancy status
    logic        [PTR_W:0]   count;
    logic                    full;
    logic                    empty;

    modport slave (
        input  req_valid, req0_opcode, req0_op_a, req0_op_b,
               req1_opcode, req1_op_a, req1_op_b,
               instruction_word, rd_ready,
        output req_ready, load_en, write_pointer, opcode, operand_a, operand_b,
               read_pointer, rd_valid, rd_data, count, full, empty
    );

    modport master (
        output req_valid, req0_opcode, req0_op_a, req0_op_b,
               req1_opcode, req1_op_a, req1_op_b,
               instruction_word, rd_ready,
        input  req_ready, load_en, write_pointer, opcode, operand_a, operand_b,
               read_pointer, rd_valid, rd_data, count, full, empty
    );
endinterface

// File: rtl/instr_register_ctrl.sv
// Shares a 32-entry instruction register (circular queue) between two round-robin writers and one reader.
// Latency: write strobe 1 cycle after accept; first rd_valid 3 cycles after accept into an empty queue.
// Backpressure: req_ready drops to 00 while full; rd_data is held until rd_ready, at most one read per 3 cycles.
module instr_register_ctrl #(
    parameter int DEPTH = 32,
    parameter int PTR_W = 5,
    parameter int OPC_W = 4,
    parameter int OPD_W = 32,
    parameter int IW_W  = 132
) (
    input  logic                  clk,
    input  logic                  reset,
    instr_register_ctrl_if.slave  bus
);

    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        RD_IDLE  = 2'd0,
        RD_FETCH = 2'd1,
        RD_VALID = 2'd2
    } rd_state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic                    r_prio;          // 0: requester 0 wins a tie, 1: requester 1 wins
    logic        [PTR_W-1:0] r_wr_ptr;
    logic        [PTR_W-1:0] r_rd_ptr;
    logic        [CNT_W-1:0] r_count;

    logic                    r_load_en;
    logic        [PTR_W-1:0] r_write_pointer;
    logic        [OPC_W-1:0] r_opcode;
    logic signed [OPD_W-1:0] r_operand_a;
    logic signed [OPD_W-1:0] r_operand_b;

    rd_state_t               r_state;
    logic        [PTR_W-1:0] r_read_pointer;
    logic                    r_rd_valid;
    logic        [IW_W-1:0]  r_rd_data;

    // ------------------------------------------------------------------
    // Combinational arbitration and handshakes
    // ------------------------------------------------------------------
    logic                    w_full;
    logic                    w_empty;
    logic                    w_grant0;
    logic                    w_grant1;
    logic                    w_accept;
    logic                    w_rd_hs;
    logic        [PTR_W-1:0] w_wr_ptr_nxt;
    logic        [PTR_W-1:0] w_rd_ptr_nxt;

    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);

    // A lone requester always wins; on a tie the priority holder wins. Nothing is granted while full.
    assign w_grant0 = !w_full && bus.req_valid[0] && (!bus.req_valid[1] || !r_prio);
    assign w_grant1 = !w_full && bus.req_valid[1] && (!bus.req_valid[0] ||  r_prio);
    assign w_accept = w_grant0 || w_grant1;

    // Entries are released only here, so a slot under fetch or presentation is never reused.
    assign w_rd_hs  = r_rd_valid && bus.rd_ready;

    // Explicit wrap keeps the queue correct even if DEPTH is not a power of two.
    assign w_wr_ptr_nxt = (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
    assign w_rd_ptr_nxt = (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;

    // ------------------------------------------------------------------
    // Round-robin priority: after an accept, the requester not just served gets the tie-break.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prio <= 1'b0;
        end else if (w_accept) begin
            r_prio <= w_grant0;
        end
    end

    // ------------------------------------------------------------------
    // Write path: register the granted payload and slot address for the register's write cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_load_en       <= 1'b0;
            r_write_pointer <= '0;
            r_opcode        <= '0;
            r_operand_a     <= '0;
            r_operand_b     <= '0;
            r_wr_ptr        <= '0;
        end else begin
            r_load_en <= w_accept;
            if (w_accept) begin
                r_write_pointer <= r_wr_ptr;
                r_opcode        <= w_grant1 ? bus.req1_opcode : bus.req0_opcode;
                r_operand_a     <= w_grant1 ? bus.req1_op_a   : bus.req0_op_a;
                r_operand_b     <= w_grant1 ? bus.req1_op_b   : bus.req0_op_b;
                r_wr_ptr        <= w_wr_ptr_nxt;
            end
        end
    end

    // ------------------------------------------------------------------
    // Occupancy: counts an entry from its accept edge until its read handshake.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else begin
            case ({w_accept, w_rd_hs})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Read sequencer: IDLE waits for an entry, FETCH lets the register's read settle
    // for one cycle and captures it, VALID holds the word until the consumer takes it.
    // An entry accepted at edge N is written at edge N+1, and FETCH samples at the
    // earliest at edge N+2, so the captured word is always the written one.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= RD_IDLE;
            r_rd_ptr       <= '0;
            r_read_pointer <= '0;
            r_rd_valid     <= 1'b0;
            r_rd_data      <= '0;
        end else begin
            case (r_state)
                RD_IDLE: begin
                    if (r_count != '0) begin
                        r_state <= RD_FETCH;
                    end
                end
                RD_FETCH: begin
                    r_rd_data  <= bus.instruction_word;
                    r_rd_valid <= 1'b1;
                    r_state    <= RD_VALID;
                end
                RD_VALID: begin
                    if (w_rd_hs) begin
                        r_rd_valid     <= 1'b0;
                        r_rd_ptr       <= w_rd_ptr_nxt;
                        r_read_pointer <= w_rd_ptr_nxt;
                        r_state        <= RD_IDLE;
                    end
                end
                default: begin
                    r_rd_valid <= 1'b0;
                    r_state    <= RD_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.req_ready     = {w_grant1, w_grant0};
    assign bus.load_en       = r_load_en;
    assign bus.write_pointer = r_write_pointer;
    assign bus.opcode        = r_opcode;
    assign bus.operand_a     = r_operand_a;
    assign bus.operand_b     = r_operand_b;
    assign bus.read_pointer  = r_read_pointer;
    assign bus.rd_valid      = r_rd_valid;
    assign bus.rd_data       = r_rd_data;
    assign bus.count         = r_count;
    assign bus.full          = w_full;
    assign bus.empty         = w_empty;

    // ------------------------------------------------------------------
    // Invariants of the queue
    // ------------------------------------------------------------------
    a_count_bounded: assert property (@(posedge clk) disable iff (reset)
        r_count <= CNT_W'(DEPTH));

    a_no_accept_when_full: assert property (@(posedge clk) disable iff (reset)
        !(w_accept && w_full));

    a_read_only_when_occupied: assert property (@(posedge clk) disable iff (reset)
        w_rd_hs |-> !w_empty);

    a_rd_data_held: assert property (@(posedge clk) disable iff (reset)
        (r_rd_valid && !bus.rd_ready) |=> (r_rd_valid && $stable(r_rd_data)));

endmodule

// File: tb/tb_instr_register_ctrl.sv
// Self-checking bench: table-driven directed rows, hand-written corner sequences and a
// randomized phase, all cross-checked by a queue-based reference model of the controller.
module tb_instr_register_ctrl;

    localparam int DEPTH = 32;
    localparam int IW    = 132;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    instr_register_ctrl_if ifc ();

    instr_register_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [IW-1:0] act, input logic [IW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Stored word layout: opcode, operand_a, operand_b, 64-bit signed product as result.
    function automatic logic [IW-1:0] mk(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] p;
        p = 64'($signed(a)) * 64'($signed(b));
        return {o, a, b, p};
    endfunction

    // Behavioural instruction register: synchronous write, combinational read.
    logic [IW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (ifc.load_en) mem[ifc.write_pointer] <= mk(ifc.opcode, ifc.operand_a, ifc.operand_b);
    end
    assign ifc.instruction_word = mem[ifc.read_pointer];

    // ------------------------------------------------------------------
    // Reference model: a FIFO of accepted words. Occupancy is its size, grants follow
    // the round-robin rule, reads must return its head in order.
    // ------------------------------------------------------------------
    logic [IW-1:0] mq [$];
    bit            m_prio = 1'b0;
    logic [4:0]    m_wp   = '0;
    logic [4:0]    m_rp   = '0;
    bit            m_load = 1'b0;
    logic [4:0]    m_lwp  = '0;
    logic [IW-1:0] m_lw   = '0;
    logic [1:0]    m_rdy;
    int            pops   = 0;

    initial forever begin
        @(negedge clk);
        if (reset) begin
            mq.delete();
            m_prio = 1'b0;
            m_wp   = '0;
            m_rp   = '0;
            m_load = 1'b0;
        end else begin
            m_rdy = 2'b00;
            if (mq.size() < DEPTH) begin
                case (ifc.req_valid)
                    2'b01:   m_rdy = 2'b01;
                    2'b10:   m_rdy = 2'b10;
                    2'b11:   m_rdy = m_prio ? 2'b10 : 2'b01;
                    default: m_rdy = 2'b00;
                endcase
            end
            chk("m_req_ready",    IW'(ifc.req_ready),    IW'(m_rdy));
            chk("m_count",        IW'(ifc.count),        IW'(mq.size()));
            chk("m_full",         IW'(ifc.full),         IW'(mq.size() == DEPTH));
            chk("m_empty",        IW'(ifc.empty),        IW'(mq.size() == 0));
            chk("m_read_pointer", IW'(ifc.read_pointer), IW'(m_rp));
            chk("m_load_en",      IW'(ifc.load_en),      IW'(m_load));
            if (m_load) begin
                chk("m_write_pointer", IW'(ifc.write_pointer), IW'(m_lwp));
                chk("m_wr_data", mk(ifc.opcode, ifc.operand_a, ifc.operand_b), m_lw);
            end
            if (ifc.rd_valid) begin
                if (mq.size() == 0) chk("m_rd_valid_when_empty", IW'(1), IW'(0));
                else                chk("m_rd_data", ifc.rd_data, mq[0]);
            end
            // advance the model by the handshakes that the coming edge will perform
            m_load = 1'b0;
            if (ifc.rd_valid && ifc.rd_ready && mq.size() > 0) begin
                void'(mq.pop_front());
                m_rp = m_rp + 5'd1;
                pops++;
            end
            if (m_rdy != 2'b00) begin
                m_lw = m_rdy[1] ? mk(ifc.req1_opcode, ifc.req1_op_a, ifc.req1_op_b)
                                : mk(ifc.req0_opcode, ifc.req0_op_a, ifc.req0_op_b);
                mq.push_back(m_lw);
                m_load = 1'b1;
                m_lwp  = m_wp;
                m_wp   = m_wp + 5'd1;
                m_prio = m_rdy[0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed table: one row per cycle after reset.
    // ------------------------------------------------------------------
    typedef struct {
        logic       rst;
        logic [1:0] rv;
        logic       rr;
        logic [1:0] x_rdy;
        logic       x_load;
        logic [4:0] x_wp;
        logic [5:0] x_cnt;
        logic       x_rvld;
        logic [3:0] x_opc;
    } vec_t;

    vec_t tbl [24];

    task automatic fixed_data();
        ifc.req0_opcode = 4'd1; ifc.req0_op_a = 32'sd5;  ifc.req0_op_b = 32'sd3;
        ifc.req1_opcode = 4'd2; ifc.req1_op_a = -32'sd7; ifc.req1_op_b = 32'sd9;
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        reset = 1'b1; ifc.req_valid = 2'b00; ifc.rd_ready = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    int acc;
    int p0;

    initial begin
        //           rst   rv     rr    rdy    load  wp     cnt    rvld  opc
        tbl[0]  = '{1'b0, 2'b01, 1'b0, 2'b01, 1'b0, 5'd0, 6'd0, 1'b0, 4'd0}; // single write from req0
        tbl[1]  = '{1'b0, 2'b00, 1'b0, 2'b00, 1'b1, 5'd0, 6'd1, 1'b0, 4'd0}; // strobe one cycle later
        tbl[2]  = '{1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 5'd0, 6'd1, 1'b0, 4'd0};
        tbl[3]  = '{1'b0, 2'b00, 1'b1, 2'b00, 1'b0, 5'd0, 6'd1, 1'b1, 4'd1}; // rd_valid at N+3
        tbl[4]  = '{1'b0, 2'b00, 1'b1, 2'b00, 1'b0, 5'd0, 6'd0, 1'b0, 4'd0}; // empty again, rd_ready no effect
        tbl[5]  = '{1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 5'd0, 6'd0, 1'b0, 4'd0}; // reset restores req0 priority
        tbl[6]  = '{1'b0, 2'b11, 1'b0, 2'b01, 1'b0, 5'd0, 6'd0, 1'b0, 4'd0}; // tie: grants alternate
        tbl[7]  = '{1'b0, 2'b11, 1'b0, 2'b10, 1'b1, 5'd0, 6'd1, 1'b0, 4'd0};
        tbl[8]  = '{1'b0, 2'b11, 1'b0, 2'b01, 1'b1, 5'd1, 6'd2, 1'b0, 4'd0};
        tbl[9]  = '{1'b0, 2'b11, 1'b0, 2'b10, 1'b1, 5'd2, 6'd3, 1'b1, 4'd1};
        tbl[10] = '{1'b0, 2'b11, 1'b0, 2'b01, 1'b1, 5'd3, 6'd4, 1'b1, 4'd1};
        tbl[11] = '{1'b0, 2'b11, 1'b0, 2'b10, 1'b1, 5'd4, 6'd5, 1'b1, 4'd1};
        tbl[12] = '{1'b0, 2'b00, 1'b0, 2'b00, 1'b1, 5'd5, 6'd6, 1'b1, 4'd1};
        tbl[13] = '{1'b0, 2'b00, 1'b1, 2'b00, 1'b0, 5'd0, 6'd6, 1'b1, 4'd1}; // drain in grant order
        tbl[14] = '{1'b0, 2'b00, 1'b1, 2'b00, 1'b0, 5'd0, 6'd5, 1'b0, 4'd0};
        tbl[15] = '{1'b0, 2'b00, 1'b1, 2'b00, 1'b0, 5'd0, 6'd5, 1'b0, 4'd0};
        tbl[16] = '{1'b0, 2'b00, 1'b1, 2'b00, 1'b0, 5'd0, 6'd5, 1'b1, 4'd2};
        tbl[17] = '{1'b0, 2'b00, 1'b1, 2'b00, 1'b0, 5'd0, 6'd4, 1'b0, 4'd0};
        tbl[18] = '{1'b0, 2'b00, 1'b1, 2'b00, 1'b0, 5'd0, 6'd4, 1'b0, 4'd0};
        tbl[19] = '{1'b0, 2'b00, 1'b1, 2'b00, 1'b0, 5'd0, 6'd4, 1'b1, 4'd1};
        tbl[20] = '{1'b0, 2'b00, 1'b1, 2'b00, 1'b0, 5'd0, 6'd3, 1'b0, 4'd0};
        tbl[21] = '{1'b0, 2'b00, 1'b1, 2'b00, 1'b0, 5'd0, 6'd3, 1'b0, 4'd0};
        tbl[22] = '{1'b0, 2'b01, 1'b1, 2'b01, 1'b0, 5'd0, 6'd3, 1'b1, 4'd2}; // accept + read same edge
        tbl[23] = '{1'b0, 2'b00, 1'b0, 2'b00, 1'b1, 5'd6, 6'd3, 1'b0, 4'd0}; // count still 3

        ifc.req_valid = 2'b00;
        ifc.rd_ready  = 1'b0;
        fixed_data();
        repeat (2) @(posedge clk);

        // ---------------- table ----------------
        for (int i = 0; i < 24; i++) begin
            @(posedge clk); #1;
            reset         = tbl[i].rst;
            ifc.req_valid = tbl[i].rv;
            ifc.rd_ready  = tbl[i].rr;
            @(negedge clk);
            if (!tbl[i].rst) begin
                chk($sformatf("tbl%0d_req_ready", i), IW'(ifc.req_ready), IW'(tbl[i].x_rdy));
                chk($sformatf("tbl%0d_load_en", i),   IW'(ifc.load_en),   IW'(tbl[i].x_load));
                chk($sformatf("tbl%0d_count", i),     IW'(ifc.count),     IW'(tbl[i].x_cnt));
                chk($sformatf("tbl%0d_rd_valid", i),  IW'(ifc.rd_valid),  IW'(tbl[i].x_rvld));
                if (tbl[i].x_load)
                    chk($sformatf("tbl%0d_write_pointer", i), IW'(ifc.write_pointer), IW'(tbl[i].x_wp));
                if (tbl[i].x_rvld)
                    chk($sformatf("tbl%0d_rd_opcode", i), IW'(ifc.rd_data[IW-1 -: 4]), IW'(tbl[i].x_opc));
            end
        end

        // ---------------- fill to full, then free one slot ----------------
        pulse_reset();
        ifc.req_valid = 2'b11;
        ifc.rd_ready  = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ifc.full) break;
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("full_flag",      IW'(ifc.full),      IW'(1));
        chk("full_count",     IW'(ifc.count),     IW'(32));
        chk("full_req_ready", IW'(ifc.req_ready), IW'(2'b00));
        @(posedge clk); #1;
        ifc.rd_ready = 1'b1;
        @(negedge clk);
        chk("full_rd_valid", IW'(ifc.rd_valid), IW'(1));
        @(posedge clk); #1;
        ifc.rd_ready = 1'b0;
        @(negedge clk);
        chk("freed_count",     IW'(ifc.count),     IW'(31));
        chk("freed_req_ready", IW'(ifc.req_ready), IW'(2'b01));
        @(posedge clk); #1;
        ifc.req_valid = 2'b00;
        @(negedge clk);
        chk("wrap_load_en",       IW'(ifc.load_en),       IW'(1));
        chk("wrap_write_pointer", IW'(ifc.write_pointer), IW'(0));
        chk("refull_count",       IW'(ifc.count),         IW'(32));

        // ---------------- steady state: 40 writes with the consumer always ready ----------------
        pulse_reset();
        p0  = pops;
        acc = 0;
        ifc.req_valid = 2'b11;
        ifc.rd_ready  = 1'b1;
        for (int i = 0; i < 400 && acc < 40; i++) begin
            @(negedge clk);
            if (ifc.req_ready != 2'b00) acc++;
            @(posedge clk); #1;
            if (acc >= 40) ifc.req_valid = 2'b00;
        end
        ifc.req_valid = 2'b00;
        for (int i = 0; i < 400 && !(ifc.empty && !ifc.rd_valid); i++) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("steady_writes", IW'(acc),        IW'(40));
        chk("steady_reads",  IW'(pops - p0),  IW'(40));
        chk("steady_empty",  IW'(ifc.empty),  IW'(1));

        // ---------------- reset while presenting, with count = 4 ----------------
        @(posedge clk); #1;
        ifc.req_valid = 2'b01;
        ifc.rd_ready  = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        ifc.req_valid = 2'b00;
        for (int i = 0; i < 10 && !ifc.rd_valid; i++) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("pre_rst_rd_valid", IW'(ifc.rd_valid), IW'(1));
        chk("pre_rst_count",    IW'(ifc.count),    IW'(4));
        @(posedge clk); #1;
        reset = 1'b1;
        ifc.req_valid = 2'b01;
        @(posedge clk); #1;
        reset = 1'b0;
        ifc.req_valid = 2'b11;
        @(negedge clk);
        chk("rst_rd_valid",     IW'(ifc.rd_valid),     IW'(0));
        chk("rst_count",        IW'(ifc.count),        IW'(0));
        chk("rst_load_en",      IW'(ifc.load_en),      IW'(0));
        chk("rst_read_pointer", IW'(ifc.read_pointer), IW'(0));
        chk("rst_rd_data",      ifc.rd_data,           IW'(0));
        chk("rst_priority",     IW'(ifc.req_ready),    IW'(2'b01));
        @(posedge clk); #1;
        ifc.req_valid = 2'b00;

        // ---------------- randomized traffic against the model ----------------
        for (int blk = 0; blk < 8; blk++) begin
            int rd_pct;
            rd_pct = (blk % 2 == 0) ? 15 : 85;
            for (int i = 0; i < 250; i++) begin
                @(posedge clk); #1;
                reset           = ($urandom_range(0, 299) == 0);
                ifc.req_valid   = 2'($urandom);
                ifc.rd_ready    = ($urandom_range(0, 99) < rd_pct);
                ifc.req0_opcode = 4'($urandom);
                ifc.req0_op_a   = $urandom;
                ifc.req0_op_b   = $urandom;
                ifc.req1_opcode = 4'($urandom);
                ifc.req1_op_a   = $urandom;
                ifc.req1_op_b   = $urandom;
            end
        end

        // drain whatever is left
        @(posedge clk); #1;
        reset         = 1'b0;
        ifc.req_valid = 2'b00;
        ifc.rd_ready  = 1'b1;
        for (int i = 0; i < 200 && !(ifc.empty && !ifc.rd_valid); i++) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("final_empty",      IW'(ifc.empty),  IW'(1));
        chk("final_model_size", IW'(mq.size()),  IW'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_register_ctrl.md
Name: instr_register_ctrl

Overview:
Controller that shares the 32-entry instruction register between two instruction producers and one consumer. It round-robin arbitrates two valid/ready write requesters and drives the register's load_en, write_pointer and operand/opcode inputs. It manages the register as a circular queue and sequences read_pointer to return stored instruction words to the consumer over a valid/ready handshake.

Parameters:
DEPTH, 32, number of instruction register entries
PTR_W, 5, pointer width, equal to log2(DEPTH)
OPC_W, 4, opcode width
OPD_W, 32, operand width (signed)
IW_W, 132, instruction_word width (opc + op_a + op_b + 64-bit result)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
req_valid[1:0]  in  2  requester i has an instruction
req_ready[1:0]  out  2  grant; transfer on req_valid[i] & req_ready[i]
req0_opcode / req1_opcode  in  OPC_W  requester opcode
req0_op_a / req1_op_a  in  OPD_W  requester operand_a
req0_op_b / req1_op_b  in  OPD_W  requester operand_b
load_en  out  1  write strobe to instruction register
write_pointer  out  PTR_W  write address
opcode  out  OPC_W  write data
operand_a  out  OPD_W  write data
operand_b  out  OPD_W  write data
read_pointer  out  PTR_W  read address
instruction_word  in  IW_W  read data from instruction register
rd_valid  out  1  rd_data holds an entry
rd_ready  in  1  consumer accepts
rd_data  out  IW_W  captured instruction word
count  out  PTR_W+1  occupied entries, 0..DEPTH
full  out  1  count == DEPTH
empty  out  1  count == 0

Behaviour:
- Reset (sync, high): wr_ptr = rd_ptr = 0; count = 0; load_en = 0; write_pointer/read_pointer/opcode/operands = 0; rd_valid = 0; rd_data = 0; read FSM = IDLE; round-robin priority = requester 0. Reset mid-operation discards all entries and any pending rd_data.
- Arbitration is combinational from req_valid, full and priority.
  - If full: req_ready = 00.
  - Else if exactly one requester is valid, it is granted.
  - If both are valid, the priority holder is granted.
  - Only one grant per cycle.
- Priority flips to the other requester after each accepted transfer. It is unchanged when no transfer occurs.
- Write path, accept at edge N:
  - Cycle N+1: registered load_en = 1, write_pointer = wr_ptr, and the granted requester's opcode/op_a/op_b.
  - The instruction register writes at the end of N+1.
  - load_en = 0 on cycles with no accept.
  - wr_ptr increments at the accept edge and wraps DEPTH-1 -> 0.
- count increments at the accept edge. It decrements on a read handshake (rd_valid & rd_ready). If both happen in the same cycle, count is unchanged. full and empty are derived from count.
- read_pointer is registered and always equals rd_ptr.
- Read FSM:
  - IDLE: if count > 0, go to FETCH; otherwise stay.
  - FETCH (one cycle): at the end of the cycle, sample instruction_word into rd_data; go to VALID.
  - VALID: rd_valid = 1. rd_data is held stable until rd_ready. On the handshake: rd_ptr++ (wrapping), count--, go to IDLE.
- Latency:
  - First write accepted at edge N into an empty controller gives rd_valid = 1 in cycle N+3.
  - Read throughput is at most one entry per 3 cycles.
- An entry is freed only on its read handshake. A write can never overwrite an entry that is unread, being fetched, or being presented.
- Full and an accept attempt: no req_ready, requester stalls. A slot frees the cycle after the read handshake.
- Empty with rd_ready high: no effect; rd_valid stays 0.
- Unsupported opcodes pass through unmodified. The controller never inspects data.

Test Plan:
1. Reset, then req0 writes opc=1, a=5, b=3 -> load_en=1 with write_pointer=0 one cycle after accept; rd_valid at N+3 with rd_data.opc=1, op_a=5, op_b=3; after handshake, count=0 and empty=1.
2. Both requesters valid for 6 cycles with rd_ready=0 -> grants alternate 0,1,0,1,0,1; write_pointer 0..5; count=6; read order matches grant order.
3. Fill 32 entries with rd_ready=0 -> full=1, req_ready=00 with req_valid=11. One read handshake -> the next cycle accepts, write_pointer wraps to 0, count returns to 32.
4. Steady state: 40 writes with rd_ready=1 -> pointers wrap past 31; all 40 words are read back in order with no loss or duplication.
5. Write accept and read handshake in the same cycle with count=3 -> count stays 3.
6. Assert reset while in VALID with count=4 -> the next cycle shows rd_valid=0, count=0, load_en=0, read_pointer=0, priority=req0.
